// File: rtl/frame_loader.sv
// Byte-stream packet parser that writes {G,R,B} pixels into the LED frame buffer write port.
// Optional CHECKSUM_EN adds a trailing XOR checksum byte checked in a CHECK state.
module frame_loader #(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [23:0]       ram_din,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_PIXEL, S_CHECK
  } state_t;
  // Payload end hands over to the checksum byte; the verdict pulses later.
  localparam state_t END_STATE = S_CHECK;
  localparam logic   END_PULSE = 1'b0;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_PIXEL
  } state_t;
  localparam state_t END_STATE = S_IDLE;
  localparam logic   END_PULSE = 1'b1;
`endif

  state_t            state;
  logic [7:0]        addr_h;
  logic [7:0]        len_h;
  logic [7:0]        pix_g;
  logic [7:0]        pix_r;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       pix_cnt;
  logic [CNT_W-1:0]  timer;    // cycles elapsed since the last accepted byte
`ifdef CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign busy = (state != S_IDLE);

  // NOTE: all state and registered outputs use non-blocking assignments and reset
  // asynchronously, so a reset mid-packet also cancels a write that is about to issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      addr_h     <= '0;
      len_h      <= '0;
      pix_g      <= '0;
      pix_r      <= '0;
      byte_idx   <= '0;
      wr_addr    <= '0;
      pix_cnt    <= '0;
      timer      <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
`ifdef CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      ram_we     <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;

      if (rx_valid) begin
        timer <= CNT_W'(1);
`ifdef CHECKSUM_EN
        if (state != S_IDLE && state != S_CHECK) csum <= csum ^ rx_data;
`endif
        case (state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state <= S_ADDR_H;
`ifdef CHECKSUM_EN
              csum  <= '0;
`endif
            end
          end
          S_ADDR_H: begin
            addr_h <= rx_data;
            state  <= S_ADDR_L;
          end
          S_ADDR_L: begin
            wr_addr <= ADDR_W'({addr_h, rx_data});
            state   <= S_LEN_H;
          end
          S_LEN_H: begin
            len_h <= rx_data;
            state <= S_LEN_L;
          end
          S_LEN_L: begin
            byte_idx <= '0;
            pix_cnt  <= {len_h, rx_data};
            if ({len_h, rx_data} == 16'd0) begin
              state      <= END_STATE;
              frame_done <= END_PULSE;
            end else begin
              state <= S_PIXEL;
            end
          end
          S_PIXEL: begin
            case (byte_idx)
              2'd0: begin
                pix_g    <= rx_data;
                byte_idx <= 2'd1;
              end
              2'd1: begin
                pix_r    <= rx_data;
                byte_idx <= 2'd2;
              end
              default: begin
                ram_we   <= 1'b1;
                ram_addr <= wr_addr;
                ram_din  <= {pix_g, pix_r, rx_data};
                wr_addr  <= wr_addr + 1'b1;
                pix_cnt  <= pix_cnt - 16'd1;
                byte_idx <= 2'd0;
                if (pix_cnt == 16'd1) begin
                  state      <= END_STATE;
                  frame_done <= END_PULSE;
                end
              end
            endcase
          end
`ifdef CHECKSUM_EN
          S_CHECK: begin
            state <= S_IDLE;
            if (rx_data == csum) frame_done <= 1'b1;
            else                 err        <= 1'b1;
          end
`endif
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        // Silence mid-packet: abort once the idle gap reaches TIMEOUT cycles.
        if (timer == CNT_W'(TIMEOUT - 1)) begin
          err      <= 1'b1;
          state    <= S_IDLE;
          timer    <= '0;
          byte_idx <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: random packets versus a packet-level reference model.
// Define CHECKSUM_EN for both bench and RTL to exercise the checksum variant.
module tb_frame_loader;

  localparam int ADDR_W = 10;
  localparam int TMO    = 50;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [23:0]       ram_din;
  logic              busy;
  logic              frame_done;
  logic              err;

  always #5 clk = ~clk;

  frame_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  int  cyc = 0;
  wr_t got_wr[$];
  wr_t exp_wr[$];
  int  got_fd[$];
  int  got_err[$];
  int  both_hi = 0;
  int  n_chk = 0;
  int  n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: each output pulse is logged with the cycle in which it is visible.
  always @(negedge clk) begin
    wr_t w;
    if (ram_we) begin
      w.cyc  = cyc;
      w.addr = int'(ram_addr);
      w.data = int'(ram_din);
      got_wr.push_back(w);
    end
    if (frame_done) got_fd.push_back(cyc);
    if (err) got_err.push_back(cyc);
    if (frame_done && err) both_hi++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int pick_gap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
  endfunction

  task automatic drive(input logic [7:0] b, input int gap, output int s);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    s        = cyc;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  function automatic longint out_vec();
    return longint'({ram_we, ram_addr, ram_din, busy, frame_done, err});
  endfunction

  // Compares everything recorded since the last call against the model's expectations.
  task automatic verify(input string tag, input int exp_fd, input int exp_err);
    wr_t g;
    wr_t e;
    int  i;
    #1;
    check({tag, ".n_writes"}, got_wr.size(), exp_wr.size());
    i = 0;
    while (got_wr.size() > 0 && exp_wr.size() > 0) begin
      g = got_wr.pop_front();
      e = exp_wr.pop_front();
      check($sformatf("%s.wr%0d.cycle", tag, i), g.cyc, e.cyc);
      check($sformatf("%s.wr%0d.addr", tag, i), g.addr, e.addr);
      check($sformatf("%s.wr%0d.data", tag, i), g.data, e.data);
      i++;
    end
    check({tag, ".n_done"}, got_fd.size(), (exp_fd >= 0) ? 1 : 0);
    if (got_fd.size() > 0 && exp_fd >= 0) check({tag, ".done_cycle"}, got_fd[0], exp_fd);
    check({tag, ".n_err"}, got_err.size(), (exp_err >= 0) ? 1 : 0);
    if (got_err.size() > 0 && exp_err >= 0) check({tag, ".err_cycle"}, got_err[0], exp_err);
    check({tag, ".busy_after"}, busy, 0);
    got_wr.delete();
    exp_wr.delete();
    got_fd.delete();
    got_err.delete();
  endtask

  // Reference model: sends one packet and predicts writes from packet content alone.
  task automatic run_packet(input string tag, input logic [15:0] addr16,
                            input logic [23:0] pix[$], input int max_gap);
    logic [7:0]  hdr[4];
    logic [7:0]  csum;
    logic [15:0] len;
    int          s;
    int          start;
    int          fd_cyc;
    wr_t         w;
    len    = 16'(pix.size());
    hdr[0] = addr16[15:8];
    hdr[1] = addr16[7:0];
    hdr[2] = len[15:8];
    hdr[3] = len[7:0];
    start  = int'(addr16) % (1 << ADDR_W);
    csum   = 8'h00;
    drive(8'hA5, pick_gap(max_gap), s);
    for (int i = 0; i < 4; i++) begin
      drive(hdr[i], pick_gap(max_gap), s);
      csum ^= hdr[i];
    end
    fd_cyc = s + 1;
    for (int p = 0; p < pix.size(); p++) begin
      for (int k = 2; k >= 0; k--) begin
        logic [7:0] b;
        b = pix[p][k*8 +: 8];
        drive(b, pick_gap(max_gap), s);
        csum ^= b;
      end
      w.cyc  = s + 1;
      w.addr = (start + p) % (1 << ADDR_W);
      w.data = int'(pix[p]);
      exp_wr.push_back(w);
      fd_cyc = s + 1;
    end
`ifdef CHECKSUM_EN
    drive(csum, 0, s);
    fd_cyc = s + 1;
`endif
    idle(4);
    verify(tag, fd_cyc, -1);
  endtask

  function automatic void rand_pixels(input int n, output logic [23:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(24'($urandom));
  endfunction

  initial begin
    logic [23:0] pix[$];
    int          s;
    int          s_b;
    wr_t         w;

    // Reset held with random traffic: every output must stay at zero.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      #1 check($sformatf("reset_hold%0d", i), out_vec(), 0);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    idle(2);
    check("reset_release", out_vec(), 0);

    // Single pixel at address 5.
    pix = '{24'h123456};
    run_packet("single", 16'h0005, pix, 0);

    // Wrap-around from the top of the buffer.
    rand_pixels(3, pix);
    run_packet("wrap", 16'h03FE, pix, 1);

    // Garbage in IDLE is ignored, then an empty packet.
    drive(8'h00, 0, s);
    drive(8'hFF, 1, s);
    drive(8'h5A, 0, s);
    pix.delete();
    run_packet("len0", 16'h0000, pix, 0);

    // Timeout after one full pixel and one partial byte.
    drive(8'hA5, 0, s);
    drive(8'h00, 0, s);
    drive(8'h00, 0, s);
    drive(8'h00, 0, s);
    drive(8'h02, 0, s);
    drive(8'h11, 0, s);
    drive(8'h22, 0, s);
    drive(8'h33, 0, s_b);
    drive(8'h44, 0, s);
    w.cyc  = s_b + 1;
    w.addr = 0;
    w.data = 24'h112233;
    exp_wr.push_back(w);
    idle(TMO - 2);
    #1 check("timeout.busy_before", busy, 1);
    check("timeout.no_early_err", got_err.size(), 0);
    idle(10);
    verify("timeout", -1, s + TMO);
    rand_pixels(2, pix);
    run_packet("after_timeout", 16'($urandom), pix, 2);

    // Asynchronous reset while a B byte is on the wire.
    drive(8'hA5, 0, s);
    drive(8'h00, 0, s);
    drive(8'h10, 0, s);
    drive(8'h00, 0, s);
    drive(8'h03, 0, s);
    drive(8'hAA, 0, s);
    drive(8'hBB, 0, s);
    drive(8'hCC, 0, s_b);
    drive(8'hDD, 0, s);
    drive(8'hEE, 0, s);
    w.cyc  = s_b + 1;
    w.addr = 16'h0010;
    w.data = 24'hAABBCC;
    exp_wr.push_back(w);
    @(negedge clk);
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    #2 reset = 1'b0;
    #1 check("rst_mid.outputs", out_vec(), 0);
    idle(3);
    reset = 1'b1;
    idle(3);
    verify("rst_mid", -1, -1);

    // Back-to-back strobes on every cycle.
    rand_pixels(2, pix);
    run_packet("b2b", 16'($urandom), pix, 0);

    // Random packets with random inter-byte gaps.
    for (int t = 0; t < 8; t++) begin
      rand_pixels(int'($urandom_range(4, 1)), pix);
      run_packet($sformatf("rand%0d", t), 16'($urandom), pix, (t % 2 == 0) ? 3 : 0);
    end

    check("done_err_exclusive", both_hi, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
